fnd_decoder: RTL and testbench

FND_DECODER -- requirements
Module: fnd_decoder

---
 rtl/fnd_decoder.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_fnd_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_decoder.sv
// ============================================================================
// Module      : fnd_decoder
// Description : Passive snooper for a multiplexed 4-digit 7-segment (FND)
//               display bus. Each digit-select/segment pair must stay stable
//               for STABLE_CYCLES samples before it is accepted. Digits are
//               collected in scan order (ones -> thousands). Only complete,
//               in-order frames containing valid patterns reach the outputs.
//
// Ports       : clk          system clock, rising edge
//               rst          synchronous reset, active-low
//               fnd_com      [3:0] digit select, active-low one-hot
//                            (bit0 = ones digit, bit3 = thousands digit)
//               fnd_data     [7:0] segments, active-low
//                            (bit7 = decimal point, bits6:0 = g..a)
//               digit0..3    [3:0] decoded digits of the last good frame
//                            (0-9, F = blank)
//               value_lo     [6:0] digit1*10 + digit0 (blank counts as 0)
//               value_hi     [6:0] digit3*10 + digit2 (blank counts as 0)
//               dp           [3:0] decimal points of the last good frame,
//                            1 = lit
//               frame_valid  one-cycle pulse when a good frame is published
//               frame_err    one-cycle pulse when a completed frame held an
//                            invalid segment pattern
//               seq_err      one-cycle pulse on an out-of-order digit
//               active       a display scan is currently being observed
//
// Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module fnd_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fnd_com,
    input  logic [7:0] fnd_data,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [6:0] value_lo,
    output logic [6:0] value_hi,
    output logic [3:0] dp,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       seq_err,
    output logic       active
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The stability counter saturates at STABLE_CYCLES, one above the accept
    // value, so the accept compare can only ever match once per stable run.
    localparam int c_STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int c_TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(STABLE_CYCLES - 1);
    localparam logic [c_STAB_W-1:0] c_STAB_MAX  = c_STAB_W'(STABLE_CYCLES);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] c_CODE_BLANK = 4'hF;
    localparam logic [3:0] c_CODE_ERR   = 4'hE;

    // Frame FSM: the encoding of WAIT_Dk equals k, so the expected position
    // can be compared directly against the decoded digit position.
    typedef enum logic [1:0] {
        WAIT_D0 = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        WAIT_D3 = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        logic [3:0] code;
        case (seg)
            7'h40:   code = 4'd0;
            7'h79:   code = 4'd1;
            7'h24:   code = 4'd2;
            7'h30:   code = 4'd3;
            7'h19:   code = 4'd4;
            7'h12:   code = 4'd5;
            7'h02:   code = 4'd6;
            7'h78:   code = 4'd7;
            7'h00:   code = 4'd8;
            7'h10:   code = 4'd9;
            7'h7F:   code = c_CODE_BLANK;
            default: code = c_CODE_ERR;
        endcase
        return code;
    endfunction

    // Numeric weight of a digit code; blank (and anything above 9) counts 0.
    function automatic logic [6:0] digit_num(input logic [3:0] code);
        logic [6:0] num;
        num = (code > 4'd9) ? 7'd0 : {3'b000, code};
        return num;
    endfunction

    // tens*10 + ones, at most 99, so 7 bits never overflow.
    function automatic logic [6:0] pair_value(input logic [3:0] tens,
                                              input logic [3:0] ones);
        logic [6:0] val;
        val = (digit_num(tens) * 7'd10) + digit_num(ones);
        return val;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [3:0]          r_com_q;
    logic [7:0]          r_data_q;
    logic [3:0]          r_com_prev;
    logic [7:0]          r_data_prev;
    logic [c_STAB_W-1:0] r_stab;
    logic [c_TMO_W-1:0]  r_tmo;

    state_t              r_state;
    logic [3:0]          r_sh_dig0;
    logic [3:0]          r_sh_dig1;
    logic [3:0]          r_sh_dig2;
    logic [2:0]          r_sh_dp;
    logic                r_err_mark;

    // ------------------------------------------------------------------------
    // Combinational decode of the current sample pair
    // ------------------------------------------------------------------------
    logic [1:0]          w_pos;
    logic                w_pos_valid;
    logic                w_same;
    logic [c_STAB_W-1:0] w_stab_next;
    logic                w_accept;
    logic                w_tmo_hit;
    logic [3:0]          w_code;
    logic                w_code_bad;
    logic                w_dp_lit;
    logic                w_in_order;

    always_comb begin
        w_pos       = 2'd0;
        w_pos_valid = 1'b0;
        case (r_com_q)
            4'b1110: begin w_pos = 2'd0; w_pos_valid = 1'b1; end
            4'b1101: begin w_pos = 2'd1; w_pos_valid = 1'b1; end
            4'b1011: begin w_pos = 2'd2; w_pos_valid = 1'b1; end
            4'b0111: begin w_pos = 2'd3; w_pos_valid = 1'b1; end
            default: begin w_pos = 2'd0; w_pos_valid = 1'b0; end
        endcase
    end

    assign w_same = w_pos_valid
                  && (r_com_q  == r_com_prev)
                  && (r_data_q == r_data_prev);

    always_comb begin
        w_stab_next = '0;
        if (w_same) begin
            w_stab_next = (r_stab == c_STAB_MAX) ? r_stab : (r_stab + 1'b1);
        end
    end

    // Accept on the edge where the counter lands on STABLE_CYCLES-1; any
    // change of the pair drops the counter back to 0 and re-arms acceptance.
    assign w_accept   = w_pos_valid && (w_stab_next == c_STAB_LAST);
    assign w_tmo_hit  = (r_tmo == c_TMO_LAST);

    assign w_code     = seg_decode(r_data_q[6:0]);
    assign w_code_bad = (w_code == c_CODE_ERR);
    assign w_dp_lit   = ~r_data_q[7];
    assign w_in_order = (w_pos == r_state);

    // ------------------------------------------------------------------------
    // Input sampling, stability and timeout counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_com_q     <= '0;
            r_data_q    <= '0;
            r_com_prev  <= '0;
            r_data_prev <= '0;
            r_stab      <= '0;
            r_tmo       <= '0;
        end else begin
            r_com_q     <= fnd_com;
            r_data_q    <= fnd_data;
            r_com_prev  <= r_com_q;
            r_data_prev <= r_data_q;
            r_stab      <= w_stab_next;
            if (w_accept) begin
                r_tmo <= '0;
            end else if (!w_tmo_hit) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= WAIT_D0;
            r_sh_dig0   <= '0;
            r_sh_dig1   <= '0;
            r_sh_dig2   <= '0;
            r_sh_dp     <= '0;
            r_err_mark  <= 1'b0;
            digit0      <= '0;
            digit1      <= '0;
            digit2      <= '0;
            digit3      <= '0;
            value_lo    <= '0;
            value_hi    <= '0;
            dp          <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            seq_err     <= 1'b0;
            active      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            seq_err     <= 1'b0;

            if (w_accept) begin
                // Acceptance beats a coincident timeout.
                active <= 1'b1;

                if (w_in_order) begin
                    case (r_state)
                        WAIT_D0: begin
                            r_sh_dig0  <= w_code;
                            r_sh_dp[0] <= w_dp_lit;
                            r_err_mark <= r_err_mark | w_code_bad;
                            r_state    <= WAIT_D1;
                        end
                        WAIT_D1: begin
                            r_sh_dig1  <= w_code;
                            r_sh_dp[1] <= w_dp_lit;
                            r_err_mark <= r_err_mark | w_code_bad;
                            r_state    <= WAIT_D2;
                        end
                        WAIT_D2: begin
                            r_sh_dig2  <= w_code;
                            r_sh_dp[2] <= w_dp_lit;
                            r_err_mark <= r_err_mark | w_code_bad;
                            r_state    <= WAIT_D3;
                        end
                        default: begin
                            // Thousands digit closes the frame.
                            if (r_err_mark || w_code_bad) begin
                                frame_err <= 1'b1;
                            end else begin
                                digit0      <= r_sh_dig0;
                                digit1      <= r_sh_dig1;
                                digit2      <= r_sh_dig2;
                                digit3      <= w_code;
                                dp          <= {w_dp_lit, r_sh_dp};
                                value_lo    <= pair_value(r_sh_dig1, r_sh_dig0);
                                value_hi    <= pair_value(w_code, r_sh_dig2);
                                frame_valid <= 1'b1;
                            end
                            r_err_mark <= 1'b0;
                            r_state    <= WAIT_D0;
                        end
                    endcase
                end else if (w_pos == 2'd0) begin
                    // A ones digit out of turn is taken as the start of a
                    // fresh frame rather than thrown away.
                    seq_err    <= 1'b1;
                    r_sh_dig0  <= w_code;
                    r_sh_dig1  <= '0;
                    r_sh_dig2  <= '0;
                    r_sh_dp    <= {2'b00, w_dp_lit};
                    r_err_mark <= w_code_bad;
                    r_state    <= WAIT_D1;
                end else begin
                    seq_err    <= 1'b1;
                    r_sh_dig0  <= '0;
                    r_sh_dig1  <= '0;
                    r_sh_dig2  <= '0;
                    r_sh_dp    <= '0;
                    r_err_mark <= 1'b0;
                    r_state    <= WAIT_D0;
                end
            end else if (w_tmo_hit) begin
                // Scan lost: drop any partial frame so a stale error mark
                // cannot poison the first frame after the display returns.
                active     <= 1'b0;
                r_err_mark <= 1'b0;
                r_state    <= WAIT_D0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fnd_decoder.sv
// ============================================================================
// Module      : tb_fnd_decoder
// Description : Directed self-checking bench for fnd_decoder.
// Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module tb_fnd_decoder;

    localparam int c_STABLE  = 4;
    localparam int c_TIMEOUT = 64;

    logic       clk;
    logic       rst;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [6:0] value_lo, value_hi;
    logic [3:0] dp;
    logic       frame_valid, frame_err, seq_err, active;

    int checks = 0;
    int errors = 0;

    // Pulse counters, sampled on the falling edge.
    int n_fv = 0;
    int n_fe = 0;
    int n_se = 0;
    int fv0, fe0, se0;

    fnd_decoder #(
        .STABLE_CYCLES  (c_STABLE),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fnd_com     (fnd_com),
        .fnd_data    (fnd_data),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .value_lo    (value_lo),
        .value_hi    (value_hi),
        .dp          (dp),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .seq_err     (seq_err),
        .active      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) n_fv <= n_fv + 1;
        if (frame_err   === 1'b1) n_fe <= n_fe + 1;
        if (seq_err     === 1'b1) n_se <= n_se + 1;
    end

    // Hold a pattern for `dwell` rising edges, return 1 time unit after the
    // last one.
    task automatic drive(input logic [3:0] c, input logic [7:0] d, input int dwell);
        fnd_com  = c;
        fnd_data = d;
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(4'b1111, 8'hFF, n);
    endtask

    task automatic scan(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3, input int dwell);
        drive(4'b1110, d0, dwell);
        drive(4'b1101, d1, dwell);
        drive(4'b1011, d2, dwell);
        drive(4'b0111, d3, dwell);
        idle(3);
    endtask

    task automatic snap();
        fv0 = n_fv;
        fe0 = n_fe;
        se0 = n_se;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        fnd_com  = 4'b1111;
        fnd_data = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h exp 0000", {digit3, digit2, digit1, digit0}); end
        checks++; if (value_lo !== 7'd0 || value_hi !== 7'd0) begin errors++; $display("FAIL reset_values got %0d/%0d exp 0/0", value_hi, value_lo); end
        checks++; if ({dp, frame_valid, frame_err, seq_err, active} !== 8'h00) begin errors++; $display("FAIL reset_flags got %b exp 00000000", {dp, frame_valid, frame_err, seq_err, active}); end
        rst = 1'b1;
        idle(2);
    endtask

    // Digits 5,3,1,2 with decimal points off.
    task automatic test_good_frame();
        snap();
        scan(8'h92, 8'hB0, 8'hF9, 8'hA4, 6);
        checks++; if (n_fv - fv0 !== 1) begin errors++; $display("FAIL good_fv_count got %0d exp 1", n_fv - fv0); end
        checks++; if ({digit3, digit2, digit1, digit0} !== 16'h2135) begin errors++; $display("FAIL good_digits got %h exp 2135", {digit3, digit2, digit1, digit0}); end
        checks++; if (value_lo !== 7'd35) begin errors++; $display("FAIL good_value_lo got %0d exp 35", value_lo); end
        checks++; if (value_hi !== 7'd21) begin errors++; $display("FAIL good_value_hi got %0d exp 21", value_hi); end
        checks++; if (dp !== 4'b0000) begin errors++; $display("FAIL good_dp got %b exp 0000", dp); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL good_active got %b exp 1", active); end
        checks++; if (n_fe - fe0 !== 0 || n_se - se0 !== 0) begin errors++; $display("FAIL good_no_err got fe=%0d se=%0d exp 0/0", n_fe - fe0, n_se - se0); end
    endtask

    // Invalid digit 1, then a clean frame with blank, decimal points and 98.
    task automatic test_frame_err();
        snap();
        scan(8'h92, 8'hA3, 8'hF9, 8'hA4, 6);
        checks++; if (n_fe - fe0 !== 1 || n_fv - fv0 !== 0) begin errors++; $display("FAIL ferr_pulses got fe=%0d fv=%0d exp 1/0", n_fe - fe0, n_fv - fv0); end
        checks++; if ({digit3, digit2, digit1, digit0} !== 16'h2135 || value_lo !== 7'd35) begin errors++; $display("FAIL ferr_hold got %h/%0d exp 2135/35", {digit3, digit2, digit1, digit0}, value_lo); end
        snap();
        scan(8'h40, 8'hFF, 8'h80, 8'h10, 6);
        checks++; if (n_fv - fv0 !== 1 || n_fe - fe0 !== 0) begin errors++; $display("FAIL ferr_recover got fv=%0d fe=%0d exp 1/0", n_fv - fv0, n_fe - fe0); end
        checks++; if ({digit3, digit2, digit1, digit0} !== 16'h98F0) begin errors++; $display("FAIL blank_digits got %h exp 98F0", {digit3, digit2, digit1, digit0}); end
        checks++; if (value_lo !== 7'd0 || value_hi !== 7'd98) begin errors++; $display("FAIL blank_values got %0d/%0d exp 98/0", value_hi, value_lo); end
        checks++; if (dp !== 4'b1001) begin errors++; $display("FAIL blank_dp got %b exp 1001", dp); end
    endtask

    // Ones then hundreds: seq_err, FSM back to WAIT_D0, so a full scan works.
    task automatic test_seq_err();
        snap();
        drive(4'b1110, 8'h92, 6);
        drive(4'b1011, 8'hF9, 6);
        idle(3);
        checks++; if (n_se - se0 !== 1 || n_fv - fv0 !== 0) begin errors++; $display("FAIL seq_pulse got se=%0d fv=%0d exp 1/0", n_se - se0, n_fv - fv0); end
        snap();
        scan(8'h92, 8'hB0, 8'hF9, 8'hA4, 6);
        checks++; if (n_fv - fv0 !== 1 || n_se - se0 !== 0) begin errors++; $display("FAIL seq_recover got fv=%0d se=%0d exp 1/0", n_fv - fv0, n_se - se0); end
    endtask

    task automatic test_dwell();
        // Too short: the ones digit is ignored, so the tens digit is out of order.
        snap();
        idle(3);
        drive(4'b1110, 8'h92, 3);
        idle(3);
        drive(4'b1101, 8'hB0, 6);
        idle(3);
        checks++; if (n_se - se0 !== 1) begin errors++; $display("FAIL dwell3 got se=%0d exp 1", n_se - se0); end
        // Minimum dwell: one acceptance per digit.
        snap();
        scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 4);
        checks++; if (n_fv - fv0 !== 1 || n_se - se0 !== 0) begin errors++; $display("FAIL dwell4 got fv=%0d se=%0d exp 1/0", n_fv - fv0, n_se - se0); end
        checks++; if ({digit3, digit2, digit1, digit0} !== 16'h4321) begin errors++; $display("FAIL dwell4_digits got %h exp 4321", {digit3, digit2, digit1, digit0}); end
        // Long dwell must not re-accept.
        snap();
        drive(4'b1110, 8'h92, 20);
        drive(4'b1101, 8'hB0, 6);
        drive(4'b1011, 8'hF9, 6);
        drive(4'b0111, 8'hA4, 6);
        idle(3);
        checks++; if (n_fv - fv0 !== 1 || n_se - se0 !== 0) begin errors++; $display("FAIL dwell20 got fv=%0d se=%0d exp 1/0", n_fv - fv0, n_se - se0); end
    endtask

    // frame_valid exactly STABLE_CYCLES+1 edges after the digit-3 pattern.
    task automatic test_latency();
        int lat;
        lat = 0;
        drive(4'b1110, 8'hF9, 6);
        drive(4'b1101, 8'hA4, 6);
        drive(4'b1011, 8'hB0, 6);
        fnd_com  = 4'b0111;
        fnd_data = 8'h99;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid === 1'b1 && lat == 0) begin
                lat = k;
                checks++; if (value_hi !== 7'd43 || value_lo !== 7'd21) begin errors++; $display("FAIL lat_values got %0d/%0d exp 43/21", value_hi, value_lo); end
            end
        end
        checks++; if (lat !== c_STABLE + 1) begin errors++; $display("FAIL latency got %0d exp %0d", lat, c_STABLE + 1); end
        idle(3);
    endtask

    task automatic test_timeout();
        idle(10);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL tmo_early got %b exp 1", active); end
        idle(c_TIMEOUT + 5);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL tmo_drop got %b exp 0", active); end
        checks++; if ({digit3, digit2, digit1, digit0} !== 16'h4321) begin errors++; $display("FAIL tmo_hold got %h exp 4321", {digit3, digit2, digit1, digit0}); end
        drive(4'b1110, 8'h92, 6);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL tmo_resume got %b exp 1", active); end
        checks++; if ({digit3, digit2, digit1, digit0} !== 16'h4321) begin errors++; $display("FAIL tmo_hold2 got %h exp 4321", {digit3, digit2, digit1, digit0}); end
        idle(3);
    endtask

    task automatic test_reset_mid_frame();
        drive(4'b1110, 8'h92, 6);
        drive(4'b1101, 8'hB0, 6);
        drive(4'b1011, 8'hF9, 6);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if ({digit3, digit2, digit1, digit0} !== 16'h0000 || value_lo !== 7'd0 || value_hi !== 7'd0) begin errors++; $display("FAIL rmid_outputs got %h %0d %0d exp 0000 0 0", {digit3, digit2, digit1, digit0}, value_hi, value_lo); end
        checks++; if ({dp, frame_valid, frame_err, seq_err, active} !== 8'h00) begin errors++; $display("FAIL rmid_flags got %b exp 00000000", {dp, frame_valid, frame_err, seq_err, active}); end
        rst = 1'b1;
        snap();
        scan(8'h90, 8'h90, 8'h90, 8'h90, 6);
        checks++; if (n_fv - fv0 !== 1 || n_se - se0 !== 0) begin errors++; $display("FAIL rmid_frame got fv=%0d se=%0d exp 1/0", n_fv - fv0, n_se - se0); end
        checks++; if (value_lo !== 7'd99 || value_hi !== 7'd99) begin errors++; $display("FAIL rmid_99 got %0d/%0d exp 99/99", value_hi, value_lo); end
        checks++; if ({digit3, digit2, digit1, digit0} !== 16'h9999 || dp !== 4'b0000) begin errors++; $display("FAIL rmid_digits got %h dp %b exp 9999 0000", {digit3, digit2, digit1, digit0}, dp); end
    endtask

    initial begin
        rst      = 1'b0;
        fnd_com  = 4'b1111;
        fnd_data = 8'hFF;
        @(posedge clk);
        #1;
        test_reset();
        test_good_frame();
        test_frame_err();
        test_seq_err();
        test_dwell();
        test_latency();
        test_timeout();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout_guard got stalled exp finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
